// File: rtl/axi_rd_burst_splitter_pkg.sv
// Shared types for the AXI read burst splitter.
// Provides the AXI burst encodings, the len/size/addr/id field types, the AR and R
// channel structs used on both ports, the {split, len} length-FIFO entry, the
// AR FSM state enum and the single-beat address stepping helper.
package axi_rd_burst_splitter_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned UserWidth = 1;

    typedef logic [1:0]           burst_t;
    typedef logic [7:0]           len_t;
    typedef logic [2:0]           size_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [DataWidth-1:0] data_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        size_t      size;
        burst_t     burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
    } ar_chan_s;

    typedef struct packed {
        id_t                  id;
        data_t                data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_s;

    // One entry per accepted AR: whether it was split, and its original len.
    typedef struct packed {
        logic split;
        len_t len;
    } len_entry_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    // Address of the next single-beat AR. INCR aligns down to the beat size
    // before stepping, so an unaligned start address lands on the next aligned beat.
    function automatic addr_t next_beat_addr(input addr_t addr, input size_t size,
                                             input burst_t burst);
        addr_t step;
        step = addr_t'(1) << size;
        if (burst == BURST_FIXED) begin
            return addr;
        end
        return (addr & ~(step - addr_t'(1))) + step;
    endfunction

endpackage

// File: rtl/axi_rd_burst_splitter_fifo.sv
// Length FIFO (fifo_v3 style) holding one {split, len} entry per outstanding AR.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, data_i     write an entry (ignored when full)
//   pop_i              drop the head entry (ignored when empty)
//   data_o             head entry
//   empty_o            no entry stored
//   usage_o            number of stored entries
module axi_rd_burst_splitter_fifo
    import axi_rd_burst_splitter_pkg::*;
#(
    parameter  int unsigned Depth = 1,
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  len_entry_t      data_i,
    input  logic            pop_i,
    output len_entry_t      data_o,
    output logic            empty_o,
    output logic [CntW-1:0] usage_o
);

    len_entry_t      mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] cnt;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (cnt != CntW'(Depth));
    assign do_pop  = pop_i && (cnt != '0);
    assign data_o  = mem[rd_ptr];
    assign empty_o = (cnt == '0);
    assign usage_o = cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_burst_splitter.sv
// AXI read burst splitter for slaves that only accept single-beat reads.
// Multi-beat INCR/FIXED non-exclusive ARs are split into len+1 single-beat ARs;
// everything else is forwarded unchanged. Returned R beats are regrouped into the
// original burst with a correct last toward the upstream converter.
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   slv_ar_i/valid_i/ready_o               AR from upstream
//   slv_r_o/valid_o/ready_i                reassembled R toward upstream
//   mst_ar_o/valid_o/ready_i               single-beat or pass-through AR toward slave
//   mst_r_i/valid_i/ready_o                R from slave
module axi_rd_burst_splitter
    import axi_rd_burst_splitter_pkg::*;
#(
    parameter int unsigned AxiMaxTrans = 1,
    parameter type         ar_chan_t   = ar_chan_s,
    parameter type         r_chan_t    = r_chan_s
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  ar_chan_t slv_ar_i,
    input  logic     slv_ar_valid_i,
    output logic     slv_ar_ready_o,
    output r_chan_t  slv_r_o,
    output logic     slv_r_valid_o,
    input  logic     slv_r_ready_i,
    output ar_chan_t mst_ar_o,
    output logic     mst_ar_valid_o,
    input  logic     mst_ar_ready_i,
    input  r_chan_t  mst_r_i,
    input  logic     mst_r_valid_i,
    output logic     mst_r_ready_o
);

    localparam int unsigned CntW = $clog2(AxiMaxTrans + 1);

    state_e          state_q;
    ar_chan_t        ar_q;
    logic            split_q;
    len_t            rem_q;
    logic            mst_valid_q;
    logic            ready_q;
    len_t            r_cnt_q;

    logic            split_in;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    len_entry_t      fifo_in;
    len_entry_t      head;
    logic [CntW-1:0] usage;
    logic [CntW-1:0] usage_next;
    logic            full_next;
    logic            r_last;

    assign split_in = ((slv_ar_i.burst == BURST_INCR) || (slv_ar_i.burst == BURST_FIXED))
                      && (slv_ar_i.len != '0) && !slv_ar_i.lock;

    assign fifo_push     = slv_ar_valid_i && slv_ar_ready_o;
    assign fifo_in.split = split_in;
    assign fifo_in.len   = slv_ar_i.len;

    axi_rd_burst_splitter_fifo #(
        .Depth (AxiMaxTrans)
    ) i_len_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .empty_o (fifo_empty),
        .usage_o (usage)
    );

    // Occupancy after this cycle's push/pop; the registered AR ready is derived
    // from it so a pop only frees a slot from the following cycle on.
    always_comb begin
        usage_next = usage;
        if (fifo_push && !fifo_pop) begin
            usage_next = usage + 1'b1;
        end else if (fifo_pop && !fifo_push) begin
            usage_next = usage - 1'b1;
        end
    end
    assign full_next = (usage_next == CntW'(AxiMaxTrans));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ar_q        <= '0;
            split_q     <= 1'b0;
            rem_q       <= '0;
            mst_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_push) begin
                        ar_q        <= slv_ar_i;
                        split_q     <= split_in;
                        rem_q       <= slv_ar_i.len;
                        mst_valid_q <= 1'b1;
                        ready_q     <= 1'b0;
                        state_q     <= ISSUE;
                    end else begin
                        ready_q <= !full_next;
                    end
                end
                ISSUE: begin
                    if (mst_valid_q && mst_ar_ready_i) begin
                        if (!split_q || (rem_q == '0)) begin
                            mst_valid_q <= 1'b0;
                            ready_q     <= !full_next;
                            state_q     <= IDLE;
                        end else begin
                            rem_q     <= rem_q - 1'b1;
                            ar_q.addr <= next_beat_addr(ar_q.addr, ar_q.size, ar_q.burst);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign slv_ar_ready_o = ready_q;
    assign mst_ar_valid_o = mst_valid_q;

    always_comb begin
        mst_ar_o = ar_q;
        if (split_q) begin
            mst_ar_o.len = '0;
        end
    end

    // Split bursts count beats to place last; pass-through bursts trust the slave.
    assign r_last        = head.split ? (r_cnt_q == head.len) : mst_r_i.last;
    assign slv_r_valid_o = mst_r_valid_i && !fifo_empty;
    assign mst_r_ready_o = slv_r_ready_i && !fifo_empty;
    assign fifo_pop      = slv_r_valid_o && slv_r_ready_i && r_last;

    always_comb begin
        slv_r_o      = mst_r_i;
        slv_r_o.last = r_last;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt_q <= '0;
        end else if (slv_r_valid_o && slv_r_ready_i) begin
            r_cnt_q <= r_last ? '0 : r_cnt_q + 1'b1;
        end
    end

    a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slv_ar_valid_i && !slv_ar_ready_o) |=> $stable(slv_ar_i));

    a_no_r_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mst_r_valid_i |-> !fifo_empty);

    a_passthru_last_pops: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mst_r_valid_i && mst_r_ready_o && !head.split && mst_r_i.last) |-> fifo_pop);

endmodule
